occ_rom_arbiter: RTL and testbench

Shares the single-port rom_Occ between NUM_REQ lookup stages, for example the k-lookup and l-lookup get_data stages.
- Arbitration is round-robin, with one new grant per clock.
- The block drives ce_rom_Occ/addr_rom_Occ and tracks in-flight reads through a ROM_LATENCY-deep tag pipeline.
- It returns each word, plus the byte lane the requester selected (A/C/G/T count), to the requester that issued the read.

---
 rtl/occ_rom_arbiter.sv | 155 +++++++++++++++
 tb/tb_occ_rom_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/occ_rom_arbiter.sv
// occ_rom_arbiter
// Shares the single-port rom_Occ between NUM_REQ lookup stages. The block
// grants one requester per clock in round-robin order, drives the ROM enable
// and address, and follows each read through a tag pipeline. When the word
// returns, it goes back to the requester that issued the read, together with
// the byte lane (A/C/G/T count) that the requester selected.
//
// Ports:
//   clk, rst_n    clock; synchronous active-low reset
//   en            arbiter enable; 0 blocks new grants
//   req           per-requester level request, held until granted
//   addr_in       packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   lane_in       packed lane selects, requester i at [i*2 +: 2]
//   gnt           one-hot grant, combinational, same cycle as the winning req
//   ce_rom_Occ    registered ROM enable
//   addr_rom_Occ  registered ROM address
//   data          ROM read data, valid ROM_LATENCY cycles after ce
//   rvalid        one-hot one-cycle response strobe
//   rdata/rbyte   returned word / selected lane; both hold while rvalid=0
//   busy          reads in flight or a response strobe pending
//
// Handshake: req[i] is a level request. When gnt[i]=1 in a cycle, the request
// is accepted at the next rising edge. If req[i] is still high in the
// following cycle, that is a new request. Responses cannot be stalled, so a
// requester must take rvalid[i] in the cycle it is asserted.
module occ_rom_arbiter #(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int ROM_LATENCY = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  input  logic [NUM_REQ*2-1:0]    lane_in,
  output logic [NUM_REQ-1:0]      gnt,
  output logic                    ce_rom_Occ,
  output logic [ADDR_W-1:0]       addr_rom_Occ,
  input  logic [DATA_W-1:0]       data,
  output logic [NUM_REQ-1:0]      rvalid,
  output logic [DATA_W-1:0]       rdata,
  output logic [7:0]              rbyte,
  output logic                    busy
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int LAST = ROM_LATENCY;

  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   win;
  logic              found;
  logic              grant;
  logic [ADDR_W-1:0] sel_addr;
  logic [1:0]        sel_lane;

  // Tag pipeline. Stage k lines up with the ROM k cycles after its ce cycle,
  // so the last stage is valid in the cycle the ROM data is valid.
  logic [LAST:0]   pv;
  logic [ID_W-1:0] pid   [LAST+1];
  logic [1:0]      plane [LAST+1];

  logic [NUM_REQ-1:0] ret_hot;
  logic [7:0]         ret_byte;

  // Scan position k of the round-robin search starting at p.
  function automatic int rr_pos(input logic [ID_W-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  // Round-robin search: the first requester at or after ptr wins.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == rr_pos(ptr, k))) begin
          found = 1'b1;
          win   = ID_W'(j);
        end
      end
    end
  end

  assign grant = found && en && rst_n;

  always_comb begin
    gnt      = '0;
    sel_addr = '0;
    sel_lane = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (win == ID_W'(j)) begin
        gnt[j]   = grant;
        sel_addr = addr_in[j*ADDR_W +: ADDR_W];
        sel_lane = lane_in[j*2 +: 2];
      end
    end
  end

  // Decode the tag that leaves the pipeline this cycle.
  always_comb begin
    ret_hot = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      ret_hot[j] = pv[LAST] && (pid[LAST] == ID_W'(j));
    end
    case (plane[LAST])
      2'd0:    ret_byte = data[7:0];
      2'd1:    ret_byte = data[15:8];
      2'd2:    ret_byte = data[23:16];
      default: ret_byte = data[31:24];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr          <= '0;
      ce_rom_Occ   <= 1'b0;
      addr_rom_Occ <= '0;
      pv           <= '0;
      rvalid       <= '0;
      rdata        <= '0;
      rbyte        <= '0;
      for (int k = 0; k <= LAST; k++) begin
        pid[k]   <= '0;
        plane[k] <= '0;
      end
    end else begin
      ce_rom_Occ   <= grant;
      addr_rom_Occ <= grant ? sel_addr : '0;
      if (grant) begin
        ptr <= (int'(win) == NUM_REQ - 1) ? '0 : win + ID_W'(1);
      end
      pv[0]    <= grant;
      pid[0]   <= win;
      plane[0] <= sel_lane;
      for (int k = 1; k <= LAST; k++) begin
        pv[k]    <= pv[k-1];
        pid[k]   <= pid[k-1];
        plane[k] <= plane[k-1];
      end
      rvalid <= ret_hot;
      if (pv[LAST]) begin
        rdata <= data;
        rbyte <= ret_byte;
      end
    end
  end

  assign busy = (|pv) || ce_rom_Occ || (|rvalid);

endmodule

// File: tb/tb_occ_rom_arbiter.sv
// Bench for occ_rom_arbiter with two requesters and a one-cycle ROM.
// A directed vector table covers the reset, round-robin, enable and lane
// cases. A hand-written streaming burst and a randomized run follow. A
// reference model checks every cycle. The model predicts the round-robin
// winner arithmetically and keeps a queue of pending reads with their due
// cycles.
module tb_occ_rom_arbiter;

  localparam int N  = 2;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int L  = 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            en;
  logic [N-1:0]    req;
  logic [N*AW-1:0] addr_in;
  logic [N*2-1:0]  lane_in;
  logic [N-1:0]    gnt;
  logic            ce_rom_Occ;
  logic [AW-1:0]   addr_rom_Occ;
  logic [DW-1:0]   data;
  logic [N-1:0]    rvalid;
  logic [DW-1:0]   rdata;
  logic [7:0]      rbyte;
  logic            busy;

  int total = 0;
  int bad   = 0;

  // clock / reset infrastructure
  always #5 clk = ~clk;

  occ_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ROM_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .addr_in(addr_in),
    .lane_in(lane_in), .gnt(gnt), .ce_rom_Occ(ce_rom_Occ),
    .addr_rom_Occ(addr_rom_Occ), .data(data), .rvalid(rvalid),
    .rdata(rdata), .rbyte(rbyte), .busy(busy)
  );

  // Behavioural ROM: data appears L cycles after the ce cycle.
  logic [DW-1:0] rom_mem [256];
  logic [DW-1:0] rom_pipe [L];
  always @(posedge clk) begin
    if (ce_rom_Occ) rom_pipe[0] <= rom_mem[addr_rom_Occ];
    for (int k = 1; k < L; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign data = rom_pipe[L-1];

  // reference model state
  typedef struct {
    int         due;
    int         id;
    logic [7:0] a;
    logic [1:0] ln;
  } pend_t;
  pend_t       exp_q[$];
  int          m_ptr;
  int          cyc;
  logic [31:0] m_rdata;
  logic [7:0]  m_rbyte;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // driver + model: one clock cycle. Inputs are applied 1 ns after posedge,
  // gnt is checked mid-cycle, and registered outputs 1 ns after the next edge.
  task automatic do_cycle(input logic r, input logic e, input logic [N-1:0] rq,
                          input logic [N*AW-1:0] av, input logic [N*2-1:0] lv,
                          output logic [N-1:0] g_seen);
    int w;
    logic [N-1:0] eg;
    logic [N-1:0] erv;
    logic [AW-1:0] ead;
    logic ece;
    logic eb;
    pend_t p;
    rst_n = r; en = e; req = rq; addr_in = av; lane_in = lv;
    w = -1;
    if (r && e) begin
      for (int k = 0; k < N; k++) begin
        if (w < 0 && rq[(m_ptr + k) % N]) w = (m_ptr + k) % N;
      end
    end
    eg = '0;
    if (w >= 0) eg[w] = 1'b1;
    #3;
    g_seen = gnt;
    chk("gnt", gnt, eg);
    @(posedge clk);
    #1;
    ece = 1'b0; ead = '0; erv = '0; eb = 1'b0;
    if (!r) begin
      exp_q.delete();
      m_ptr = 0;
      m_rdata = '0;
      m_rbyte = '0;
      cyc++;
    end else begin
      if (w >= 0) begin
        p.due = cyc + 2 + L;
        p.id  = w;
        p.a   = av[w*AW +: AW];
        p.ln  = lv[w*2 +: 2];
        exp_q.push_back(p);
        m_ptr = (w + 1) % N;
        ece = 1'b1;
        ead = p.a;
      end
      cyc++;
      eb = (exp_q.size() > 0);
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        p = exp_q.pop_front();
        erv[p.id] = 1'b1;
        m_rdata = rom_mem[p.a];
        m_rbyte = 8'(m_rdata >> (p.ln * 8));
      end
    end
    chk("ce_rom_Occ", ce_rom_Occ, ece);
    chk("addr_rom_Occ", addr_rom_Occ, ead);
    chk("rvalid", rvalid, erv);
    chk("rdata", rdata, m_rdata);
    chk("rbyte", rbyte, m_rbyte);
    chk("busy", busy, eb);
  endtask

  // directed vectors: inputs, then gnt during the cycle, then ce/addr/rvalid/busy
  // seen after the edge
  typedef struct {
    logic       r, e;
    logic [1:0] rq;
    logic [7:0] a0, a1;
    logic [1:0] l0, l1;
    logic [1:0] g;
    logic       ce;
    logic [7:0] ad;
    logic [1:0] rv;
    logic       b;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [1:0] rq,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic [1:0] l0, input logic [1:0] l1,
                     input logic [1:0] g, input logic ce, input logic [7:0] ad,
                     input logic [1:0] rv, input logic b);
    vec_t v;
    v.r = r; v.e = e; v.rq = rq; v.a0 = a0; v.a1 = a1; v.l0 = l0; v.l1 = l1;
    v.g = g; v.ce = ce; v.ad = ad; v.rv = rv; v.b = b;
    tbl.push_back(v);
  endtask

  initial begin
    logic [N-1:0] gs;
    logic [7:0]   want_byte;
    for (int i = 0; i < 256; i++) begin
      rom_mem[i] = {8'(i), 8'(i ^ 8'h5A), 8'(~i), 8'(i + 3)};
    end
    rom_mem[5] = 32'hDDCCBBAA;
    rom_mem[9] = 32'h44332211;
    cyc = 0; m_ptr = 0; m_rdata = '0; m_rbyte = '0;
    rst_n = 1'b0; en = 1'b0; req = '0; addr_in = '0; lane_in = '0;
    @(posedge clk); #1;

    // reset state
    do_cycle(1'b0, 1'b1, 2'b00, '0, '0, gs);
    do_cycle(1'b0, 1'b1, 2'b11, '0, '0, gs);

    //   r     e     rq     a0     a1     l0    l1     g     ce    ad     rv     b
    // single read, lane G
    add(1'b1, 1'b1, 2'b01, 8'h05, 8'h00, 2'd2, 2'd0, 2'b01, 1'b1, 8'h05, 2'b00, 1'b1);
    add(1'b1, 1'b1, 2'b00, 8'h05, 8'h00, 2'd2, 2'd0, 2'b00, 1'b0, 8'h00, 2'b00, 1'b1);
    add(1'b1, 1'b1, 2'b00, 8'h05, 8'h00, 2'd2, 2'd0, 2'b00, 1'b0, 8'h00, 2'b01, 1'b1);
    // reset, then alternating grants
    add(1'b0, 1'b1, 2'b00, 8'h00, 8'h00, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
    add(1'b1, 1'b1, 2'b11, 8'h01, 8'h02, 2'd0, 2'd1, 2'b01, 1'b1, 8'h01, 2'b00, 1'b1);
    add(1'b1, 1'b1, 2'b11, 8'h01, 8'h02, 2'd0, 2'd1, 2'b10, 1'b1, 8'h02, 2'b00, 1'b1);
    add(1'b1, 1'b1, 2'b11, 8'h01, 8'h02, 2'd0, 2'd1, 2'b01, 1'b1, 8'h01, 2'b01, 1'b1);
    add(1'b1, 1'b1, 2'b11, 8'h01, 8'h02, 2'd0, 2'd1, 2'b10, 1'b1, 8'h02, 2'b10, 1'b1);
    // enable off with outstanding reads
    add(1'b1, 1'b0, 2'b11, 8'h01, 8'h02, 2'd0, 2'd1, 2'b00, 1'b0, 8'h00, 2'b01, 1'b1);
    add(1'b1, 1'b0, 2'b11, 8'h01, 8'h02, 2'd0, 2'd1, 2'b00, 1'b0, 8'h00, 2'b10, 1'b1);
    add(1'b1, 1'b0, 2'b11, 8'h01, 8'h02, 2'd0, 2'd1, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
    // reset one cycle after a grant discards the read and clears ptr
    add(1'b1, 1'b1, 2'b01, 8'h03, 8'h00, 2'd0, 2'd0, 2'b01, 1'b1, 8'h03, 2'b00, 1'b1);
    add(1'b0, 1'b1, 2'b11, 8'h03, 8'h00, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
    add(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);
    add(1'b1, 1'b1, 2'b11, 8'h04, 8'h06, 2'd0, 2'd0, 2'b01, 1'b1, 8'h04, 2'b00, 1'b1);
    add(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b00, 1'b1);
    add(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b01, 1'b1);
    // lanes A, C, T of word 9
    add(1'b1, 1'b1, 2'b01, 8'h09, 8'h00, 2'd0, 2'd0, 2'b01, 1'b1, 8'h09, 2'b00, 1'b1);
    add(1'b1, 1'b1, 2'b01, 8'h09, 8'h00, 2'd1, 2'd0, 2'b01, 1'b1, 8'h09, 2'b00, 1'b1);
    add(1'b1, 1'b1, 2'b01, 8'h09, 8'h00, 2'd3, 2'd0, 2'b01, 1'b1, 8'h09, 2'b01, 1'b1);
    add(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b01, 1'b1);
    add(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b01, 1'b1);
    add(1'b1, 1'b1, 2'b00, 8'h00, 8'h00, 2'd0, 2'd0, 2'b00, 1'b0, 8'h00, 2'b00, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      do_cycle(tbl[i].r, tbl[i].e, tbl[i].rq, {tbl[i].a1, tbl[i].a0},
               {tbl[i].l1, tbl[i].l0}, gs);
      chk("tbl_gnt", gs, tbl[i].g);
      chk("tbl_ce", ce_rom_Occ, tbl[i].ce);
      chk("tbl_addr", addr_rom_Occ, tbl[i].ad);
      chk("tbl_rvalid", rvalid, tbl[i].rv);
      chk("tbl_busy", busy, tbl[i].b);
      want_byte = 8'h00;
      case (i)
        2:  want_byte = 8'hCC;
        19: want_byte = 8'h11;
        20: want_byte = 8'h22;
        21: want_byte = 8'h44;
        default: want_byte = 8'h00;
      endcase
      if (want_byte != 8'h00) chk("tbl_rbyte", rbyte, want_byte);
    end

    // streaming burst: requester 0 back to back, addresses 0..7
    for (int a = 0; a < 8; a++) begin
      do_cycle(1'b1, 1'b1, 2'b01, {8'h00, 8'(a)}, 4'b0000, gs);
      chk("burst_ce", ce_rom_Occ, 1'b1);
    end
    for (int k = 0; k < 4; k++) do_cycle(1'b1, 1'b1, 2'b00, '0, '0, gs);

    // randomized traffic with occasional reset and enable drops
    for (int k = 0; k < 400; k++) begin
      do_cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 5) != 0),
               N'($urandom_range(0, 3)), (N*AW)'($urandom),
               (N*2)'($urandom_range(0, 15)), gs);
    end
    for (int k = 0; k < 6; k++) do_cycle(1'b1, 1'b1, 2'b00, '0, '0, gs);
    chk("final_busy", busy, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
